hack_ctrl: RTL and testbench
============================

Name: hack_ctrl

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 16-bit Hack-style datapath.
- Fetches instructions over an instruction-memory handshake and decodes A- and C-instructions.
- Drives the control inputs of the external combinational ALU and sequences data-memory reads and writes for the M operand.
- Owns the A, D and PC registers and resolves jumps.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  16  fetch address (= PC)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  16  data address
- dmem_wdata  out  16  write data
- dmem_ack  in  1  access complete; dmem_rdata valid on read
- dmem_rdata  in  16  read data
- alu_x  out  16  ALU X operand (= D)
- alu_y  out  16  ALU Y operand (A or M)
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits
- alu_out  in  16  ALU result, combinational from alu_x/alu_y/controls
- pc  out  16  current PC
- a_reg  out  16  A register
- d_reg  out  16  D register
- retired  out  1  one-cycle pulse when an instruction completes

Behaviour:
- Clock and reset: single clock domain; rst_n is asynchronous active-low.
- Reset values: pc=RESET_PC; a_reg, d_reg, instruction register and M latch = 0; state=FETCH; all req/we/retired outputs = 0; ALU controls = 0.
- Handshakes:
  - req is held high with address/we/wdata stable until ack is sampled high at a clock edge.
  - req deasserts the cycle after that edge.
  - Zero-wait ack (ack in the first req cycle) is legal.
  - ack while req is low is ignored.
- FETCH state:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: latch imem_rdata into instr.
  - If instr[15]=0 (A-instruction): go EXEC; otherwise, if instr[12]=1, go READ_M; else go EXEC.
- READ_M state:
  - dmem_req=1, dmem_we=0, dmem_addr=a_reg.
  - On dmem_ack: latch M, go EXEC.
- EXEC state (exactly one cycle):
  - A-instruction: a_reg <= {1'b0, instr[14:0]}; pc <= pc+1; retired=1; go FETCH.
  - C-instruction decode: ALU controls = instr[11:6] (zx,nx,zy,ny,f,no); alu_x=d_reg; alu_y = instr[12] ? M : a_reg.
  - C-instruction register updates:
    - d_reg <= alu_out if instr[4].
    - a_reg <= alu_out if instr[5].
    - result <= alu_out; waddr <= a_reg (old value).
    - pc <= jump ? a_reg (old value) : pc+1.
  - C-instruction next state: if instr[3], go WRITE_M; else retired=1 and go FETCH.
- Jump condition: lt=alu_out[15]; eq=(alu_out==0); gt=!lt&&!eq; jump = (instr[2]&&lt) || (instr[1]&&eq) || (instr[0]&&gt).
  - Flags come from alu_out directly, not from any ALU status output.
- WRITE_M state:
  - dmem_req=1, dmem_we=1, dmem_addr=waddr, dmem_wdata=result.
  - On dmem_ack: retired=1, go FETCH.
- ALU control outputs are driven from instr in every state; consumers sample them only in EXEC.
- instr[14:13] are ignored; bit15=1 is always a C-instruction.
- Arithmetic: PC increment wraps 16'hFFFF -> 16'h0000.
- Latency with zero-wait acks:
  - A-instruction or C-instruction without M: 2 cycles.
  - C-instruction with M read: 3 cycles.
  - C-instruction with M write: 3 cycles.
  - C-instruction with both M read and M write: 4 cycles.
- Reset mid-operation: req outputs drop immediately (asynchronously); any in-flight ack is ignored; the first request after release goes to RESET_PC.

Decomposition:
- hack_pkg:
  - state enum: FETCH, READ_M, EXEC, WRITE_M.
  - instruction field constants: TYPE_BIT=15, A_BIT=12, COMP_MSB/LSB=11/6, DEST_A=5, DEST_D=4, DEST_M=3, JMP_LT/EQ/GT=2/1/0.
- hack_jump_unit: one natural combinational sub-module (alu_out, jbits -> jump).

Test Plan:
- A-instruction 0x0005 then 0xEC10 (D=A), zero-wait acks -> a_reg=5, d_reg=5, pc=2, two retired pulses, 4 cycles total.
- A=100, D=7, then 0xE7F8 (AMD=D+1) -> one dmem write addr=100 data=8, we=1; afterwards a_reg=8, d_reg=8, pc+1.
- A=0x0200, then 0xFC10 (D=M), dmem_ack delayed 3 cycles, rdata=0x1234 -> dmem_we=0, req held stable 4 cycles, d_reg=0x1234.
- A=0x0040, D=0, then 0xE302 (D;JEQ) -> pc=0x0040; repeat with D=1 -> pc+1; with D=0x8000 and 0xE304 (D;JLT) -> pc=0x0040.
- A=0x0010, then 0xEA87 (0;JMP) -> pc=0x0010; at pc=0xFFFF an A-instruction -> pc wraps to 0x0000.
- rst_n low while imem_req high and imem_ack pending -> imem_req=0 in the same cycle, pc=RESET_PC; after release the first fetch address is RESET_PC and no retired pulse has occurred.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared state encoding and instruction field positions for the Hack-style sequencer.
package hack_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    READ_M  = 2'd1,
    EXEC    = 2'd2,
    WRITE_M = 2'd3
  } state_e;

  localparam int TYPE_BIT = 15;
  localparam int A_BIT    = 12;
  localparam int COMP_MSB = 11;
  localparam int COMP_LSB = 6;
  localparam int DEST_A   = 5;
  localparam int DEST_D   = 4;
  localparam int DEST_M   = 3;
  localparam int JMP_LT   = 2;
  localparam int JMP_EQ   = 1;
  localparam int JMP_GT   = 0;

endpackage

// File: rtl/hack_jump_unit.sv
// Jump resolution from the raw ALU result and the instruction's three jump bits.
module hack_jump_unit
  import hack_pkg::*;
(
  input  logic [15:0] alu_out,
  input  logic [2:0]  jbits,
  output logic        jump
);

  logic lt, eq, gt;

  always_comb begin
    lt   = alu_out[15];
    eq   = (alu_out == 16'h0000);
    gt   = !lt && !eq;
    jump = (jbits[JMP_LT] && lt) || (jbits[JMP_EQ] && eq) || (jbits[JMP_GT] && gt);
  end

endmodule

// File: rtl/hack_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer owning the A, D and PC registers.
//   state   | meaning
//   FETCH   | request instruction at pc, latch it on imem_ack
//   READ_M  | read M from dmem[a_reg]
//   EXEC    | single-cycle register update and jump resolution
//   WRITE_M | write the ALU result to dmem[old a_reg]
module hack_ctrl
  import hack_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  output logic [15:0] pc,
  output logic [15:0] a_reg,
  output logic [15:0] d_reg,
  output logic        retired
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] m_q, m_d;
  logic [15:0] result_q, result_d;
  logic [15:0] waddr_q, waddr_d;
  logic        is_c;
  logic        jump;

  assign is_c = instr_q[TYPE_BIT];

  hack_jump_unit u_jump (
    .alu_out (alu_out),
    .jbits   (instr_q[JMP_LT:JMP_GT]),
    .jump    (jump)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      a_q      <= 16'h0000;
      d_q      <= 16'h0000;
      instr_q  <= 16'h0000;
      m_q      <= 16'h0000;
      result_q <= 16'h0000;
      waddr_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      d_q      <= d_d;
      instr_q  <= instr_d;
      m_q      <= m_d;
      result_q <= result_d;
      waddr_q  <= waddr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    a_d      = a_q;
    d_d      = d_q;
    instr_d  = instr_q;
    m_d      = m_q;
    result_d = result_q;
    waddr_d  = waddr_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = (imem_rdata[TYPE_BIT] && imem_rdata[A_BIT]) ? READ_M : EXEC;
        end
      end
      READ_M: begin
        if (dmem_ack) begin
          m_d     = dmem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!is_c) begin
          a_d     = {1'b0, instr_q[14:0]};
          pc_d    = pc_q + 16'd1;
          state_d = FETCH;
        end else begin
          if (instr_q[DEST_D]) d_d = alu_out;
          if (instr_q[DEST_A]) a_d = alu_out;
          result_d = alu_out;
          // jump target and write address both use A as it was before this update
          waddr_d  = a_q;
          pc_d     = jump ? a_q : pc_q + 16'd1;
          state_d  = instr_q[DEST_M] ? WRITE_M : FETCH;
        end
      end
      WRITE_M: begin
        if (dmem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    // requests are gated by rst_n so they drop the moment reset asserts
    imem_req   = rst_n && (state_q == FETCH);
    imem_addr  = pc_q;
    dmem_req   = rst_n && ((state_q == READ_M) || (state_q == WRITE_M));
    dmem_we    = (state_q == WRITE_M);
    dmem_addr  = (state_q == WRITE_M) ? waddr_q : a_q;
    dmem_wdata = result_q;
    retired    = ((state_q == EXEC) && !(is_c && instr_q[DEST_M])) ||
                 ((state_q == WRITE_M) && dmem_ack);
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = instr_q[COMP_MSB:COMP_LSB];
    alu_x      = d_q;
    alu_y      = instr_q[A_BIT] ? m_q : a_q;
    pc         = pc_q;
    a_reg      = a_q;
    d_reg      = d_q;
  end

endmodule

// File: tb/tb_hack_ctrl.sv
// Scoreboard bench for hack_ctrl: program-driven imem/dmem/ALU models, retire and dmem monitors.
module tb_hack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retired;
  logic [15:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] alu_x, alu_y, alu_out, pc, a_reg, d_reg;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;

  logic [15:0] imem [0:65535];
  logic [15:0] dmem_rval;
  int imem_delay = 0, dmem_delay = 0, icnt = 0, dcnt = 0, cyc = 0;
  int vectors = 0, miscompares = 0;
  int ret_cnt = 0, last_ret_cyc = 0, rd_hold = 0, c0 = 0;
  logic checking = 1'b0, ret_pend = 1'b0;

  typedef struct packed {logic [15:0] pc; logic [15:0] a; logic [15:0] d;} st_t;
  typedef struct {logic [15:0] addr; logic we; logic [15:0] data;} mem_t;
  st_t  exp_q[$];
  mem_t exp_m[$];

  always #5 clk = ~clk;

  hack_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .pc(pc), .a_reg(a_reg), .d_reg(d_reg), .retired(retired)
  );

  function automatic logic [15:0] alu_model(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign alu_out    = alu_model(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
  assign imem_ack   = imem_req && (icnt >= imem_delay);
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt >= dmem_delay);
  assign dmem_rdata = dmem_rval;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0d, expected none", name, act);
  endtask

  initial forever begin
    @(negedge clk);
    if (ret_pend) begin
      st_t e;
      ret_pend = 1'b0;
      if (exp_q.size() == 0) flag("unexpected_retire", int'(pc));
      else begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("a_reg", a_reg, e.a);
        chk("d_reg", d_reg, e.d);
      end
    end
    if (rst_n && retired) begin
      ret_cnt++;
      last_ret_cyc = cyc;
      if (checking) ret_pend = 1'b1;
    end
    if (checking && rst_n && dmem_req && dmem_ack) begin
      mem_t m;
      if (exp_m.size() == 0) flag("unexpected_dmem", int'(dmem_addr));
      else begin
        m = exp_m.pop_front();
        chk("dmem_addr", dmem_addr, m.addr);
        chk("dmem_we", {15'd0, dmem_we}, {15'd0, m.we});
        if (m.we) chk("dmem_wdata", dmem_wdata, m.data);
      end
    end
    if (rst_n && dmem_req && !dmem_we && dmem_addr == 16'h0200) rd_hold++;
  end

  task automatic er(input logic [15:0] p, input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back({p, a, d});
  endtask

  task automatic em(input logic [15:0] addr, input logic we, input logic [15:0] data);
    mem_t m;
    m.addr = addr; m.we = we; m.data = data;
    exp_m.push_back(m);
  endtask

  // hold reset, clear the program memory and expectations
  task automatic setup();
    checking = 1'b0;
    rst_n = 1'b0;
    foreach (imem[i]) imem[i] = 16'h0000;
    exp_q.delete();
    exp_m.delete();
    imem_delay = 0;
    dmem_delay = 0;
    dmem_rval = 16'h0000;
    rd_hold = 0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    checking = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 || exp_m.size() != 0) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 300) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout_%s: got %0d pending, expected 0", name, exp_q.size() + exp_m.size());
        break;
      end
    end
    checking = 1'b0;
    rst_n = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_a", a_reg, 16'h0000);
    chk("rst_d", d_reg, 16'h0000);
    chk("rst_imem_req", {15'd0, imem_req}, 16'h0000);
    chk("rst_dmem_req", {15'd0, dmem_req}, 16'h0000);
    chk("rst_retired", {15'd0, retired}, 16'h0000);
    chk("rst_alu_ctl", {10'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 16'h0000);

    // A=5 then D=A
    setup();
    imem[0] = 16'h0005; imem[1] = 16'hEC10;
    er(16'd1, 16'd5, 16'd0); er(16'd2, 16'd5, 16'd5);
    release_rst();
    wait_done("a_then_c");
    chk("latency_a_c", 16'(last_ret_cyc - c0 + 1), 16'd4);

    // D=7, A=100, AMD=D+1
    setup();
    imem[0] = 16'h0007; imem[1] = 16'hEC10; imem[2] = 16'h0064; imem[3] = 16'hE7F8;
    er(16'd1, 16'd7, 16'd0); er(16'd2, 16'd7, 16'd7); er(16'd3, 16'd100, 16'd7);
    em(16'd100, 1'b1, 16'd8);
    er(16'd4, 16'd8, 16'd8);
    release_rst();
    wait_done("amd_write");

    // D=M with dmem ack delayed three cycles
    setup();
    imem[0] = 16'h0200; imem[1] = 16'hFC10;
    dmem_delay = 3; dmem_rval = 16'h1234;
    er(16'd1, 16'h0200, 16'd0);
    em(16'h0200, 1'b0, 16'h0000);
    er(16'd2, 16'h0200, 16'h1234);
    release_rst();
    wait_done("d_eq_m");
    chk("read_hold_cycles", 16'(rd_hold), 16'd4);

    // D=0; JEQ taken
    setup();
    imem[0] = 16'h0040; imem[1] = 16'hE302;
    er(16'd1, 16'h0040, 16'd0); er(16'h0040, 16'h0040, 16'd0);
    release_rst();
    wait_done("jeq_taken");

    // D=1; JEQ not taken
    setup();
    imem[0] = 16'h0001; imem[1] = 16'hEC10; imem[2] = 16'h0040; imem[3] = 16'hE302;
    er(16'd1, 16'd1, 16'd0); er(16'd2, 16'd1, 16'd1);
    er(16'd3, 16'h0040, 16'd1); er(16'd4, 16'h0040, 16'd1);
    release_rst();
    wait_done("jeq_not_taken");

    // D=0x8000 built as 0x7FFF+1; JLT taken
    setup();
    imem[0] = 16'h7FFF; imem[1] = 16'hEC10; imem[2] = 16'hE7D0; imem[3] = 16'h0040; imem[4] = 16'hE304;
    er(16'd1, 16'h7FFF, 16'd0); er(16'd2, 16'h7FFF, 16'h7FFF); er(16'd3, 16'h7FFF, 16'h8000);
    er(16'd4, 16'h0040, 16'h8000); er(16'h0040, 16'h0040, 16'h8000);
    release_rst();
    wait_done("jlt_taken");

    // unconditional jump, then A=-1 and jump to 0xFFFF, then pc wraps
    setup();
    imem[0] = 16'h0010; imem[1] = 16'hEA87;
    imem[16'h0010] = 16'hEEA0; imem[16'h0011] = 16'hEA87; imem[16'hFFFF] = 16'h0003;
    er(16'd1, 16'h0010, 16'd0); er(16'h0010, 16'h0010, 16'd0);
    er(16'h0011, 16'hFFFF, 16'd0); er(16'hFFFF, 16'hFFFF, 16'd0);
    er(16'h0000, 16'h0003, 16'd0);
    release_rst();
    wait_done("jmp_wrap");

    // reset while a fetch is waiting for its ack
    setup();
    imem[0] = 16'h0005; imem[1] = 16'h0006;
    er(16'd1, 16'd5, 16'd0); er(16'd2, 16'd6, 16'd0);
    release_rst();
    while (exp_q.size() != 0 && cyc - c0 < 50) begin
      @(negedge clk);
      #1;
    end
    chk("pre_reset_retires", 16'(exp_q.size()), 16'd0);
    imem_delay = 5;
    checking = 1'b0;
    @(negedge clk);
    #1;
    chk("pending_fetch_req", {15'd0, imem_req}, 16'h0001);
    chk("pending_fetch_addr", imem_addr, 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    ret_cnt = 0;
    chk("req_drop_async", {15'd0, imem_req}, 16'h0000);
    chk("reset_pc_mid", pc, 16'h0000);
    chk("reset_a_mid", a_reg, 16'h0000);
    repeat (2) @(negedge clk);
    imem_delay = 0;
    rst_n = 1'b1;
    #1;
    chk("first_fetch_req", {15'd0, imem_req}, 16'h0001);
    chk("first_fetch_addr", imem_addr, 16'h0000);
    chk("no_retire_after_reset", 16'(ret_cnt), 16'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
